pmswitch_metadata_output_stream: RTL and testbench
==================================================

// Module: pmswitch_metadata_output_stream
// PURPOSE
//  Buffered, parametrised PMSwitch metadata unpacker on an AXI-stream input.
//  - Queues packed metadata words {ackCount, PMSwitchOPS, hashedAddress} in a FIFO.
//  - Presents the head entry as split fields with a valid/ready handshake.
//  - After each popped entry, issues ackCount individual ack beats, tagged with that entry's address.
//  - Sits between the PMSwitch pipeline metadata output and the persist/ack logic.
// PARAMETERS
//  ADDR_W   32  hashedAddress field width, tdata[ADDR_W-1:0]
//  OPS_W    8   PMSwitchOPS field width, next bits above address
//  ACK_W    8   ackCount field width, top bits
//  DEPTH    4   FIFO entries; power of 2, >=2
//  ACK_EN   1   1: expand ackCount into ack beats; 0: ack port tied off, never enter ACK
//  (localparam META_W = ADDR_W+OPS_W+ACK_W; defaults give 48)
// PORTS
//  aclk          in   1               clock, all logic rising edge
//  aresetn       in   1               synchronous reset, active low
//  s_meta_tdata  in   META_W          packed metadata word
//  s_meta_tvalid in   1               input valid
//  s_meta_tready out  1               input ready
//  m_addr        out  ADDR_W          head hashedAddress
//  m_ops         out  OPS_W           head PMSwitchOPS
//  m_ack_count   out  ACK_W           head ackCount
//  m_valid       out  1               head entry valid
//  m_ready       in   1               consumer accepts head entry
//  ack_valid     out  1               ack beat valid
//  ack_addr      out  ADDR_W          address of the entry being acked
//  ack_ready     in   1               ack consumer ready
//  fifo_count    out  $clog2(DEPTH)+1 entries held
//  acks_issued   out  32              total ack handshakes; wraps modulo 2^32
// BEHAVIOUR
//  Reset (aresetn=0 at edge):
//   - Pointers, fifo_count, acks_issued, ack remaining counter and ack_addr reg cleared.
//   - State returns to IDLE; ack_valid=0, m_valid=0, s_meta_tready=1 in the cycle after reset.
//   - Reset mid-ACK or with a non-empty FIFO discards everything.
//  FIFO:
//   - Write on s_meta_tvalid&&s_meta_tready.
//   - s_meta_tready = (fifo_count!=DEPTH) only; a pop in the same cycle does not open a full FIFO.
//   - No bypass: an entry written in cycle N appears on m_* in cycle N+1 at earliest.
//   - Simultaneous write and pop when neither full nor empty: both occur, count unchanged.
//   - Pointers wrap modulo DEPTH.
//  Field split (head entry):
//   - m_addr = [ADDR_W-1:0]; m_ops = [ADDR_W+OPS_W-1:ADDR_W]; m_ack_count = [META_W-1:ADDR_W+OPS_W].
//   - m_addr, m_ops, m_ack_count are driven 0 whenever m_valid=0.
//  States:
//   - IDLE: m_valid = (fifo_count!=0); ack_valid=0.
//       Pop on m_valid&&m_ready.
//       If ACK_EN and popped m_ack_count!=0: latch rem=m_ack_count and ack_addr=m_addr; go to ACK.
//       Otherwise stay in IDLE; back-to-back pops are allowed, one per cycle.
//   - ACK: m_valid=0 (head held); ack_valid=1.
//       Each ack_valid&&ack_ready: rem-=1, acks_issued+=1.
//       Handshake with rem==1: return to IDLE next cycle; next pop possible that cycle.
//   - An entry with ackCount=N costs 1+N cycles minimum; ackCount=0 costs 1.
//   - Input writes continue during ACK until the FIFO is full.
//   - ack_valid, once high, stays high until its handshake (AXI rule); ack_addr is stable meanwhile.
//  ACK_EN=0: ack_valid=0, ack_addr=0, acks_issued=0 always.
// TESTING
//  T1:
//   - Reset, then one word 48'h03_05_DEADBEEF with m_ready=1, ack_ready=1.
//   - m_valid 1 cycle after the input handshake, fields 32'hDEADBEEF/8'h05/8'h03.
//   - Then 3 ack beats with ack_addr=DEADBEEF; acks_issued=3; back to IDLE.
//  T2:
//   - m_ready=0; push DEPTH+1 words.
//   - s_meta_tready drops after 4 writes; fifo_count=4.
//   - Pop+push in the same cycle while full: push refused.
//  T3:
//   - Entries ackCount=0,0,2 with m_ready=1, ack_ready=1.
//   - Pops in consecutive cycles, then 2 acks; no ack beats for the zero-count entries.
//  T4:
//   - ackCount=8'hFF with ack_ready toggling 1/0.
//   - Exactly 255 handshakes; ack_valid never drops early; m_valid=0 throughout ACK.
//  T5:
//   - Assert aresetn=0 during ACK with 2 entries queued.
//   - Next cycle: ack_valid=0, m_valid=0, fifo_count=0, acks_issued=0, s_meta_tready=1.
//  T6:
//   - ADDR_W=40, OPS_W=4, ACK_W=4, DEPTH=8, ACK_EN=0.
//   - Correct 48-bit field split, 8-deep fill, ack_valid stays 0.

Source files
------------

// File: rtl/pmswitch_metadata_output_stream.sv
// PMSwitch metadata output stream.
// Buffers packed {ackCount, PMSwitchOPS, hashedAddress} words in a small FIFO,
// presents the head entry as split fields, and after each popped entry with a
// non-zero ackCount emits that many ack beats tagged with the entry's address.
module pmswitch_metadata_output_stream #(
    parameter int ADDR_W = 32,
    parameter int OPS_W  = 8,
    parameter int ACK_W  = 8,
    parameter int DEPTH  = 4,
    parameter int ACK_EN = 1,
    localparam int META_W = ADDR_W + OPS_W + ACK_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [META_W-1:0] s_meta_tdata,
    input  logic              s_meta_tvalid,
    output logic              s_meta_tready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [OPS_W-1:0]  m_ops,
    output logic [ACK_W-1:0]  m_ack_count,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              ack_valid,
    output logic [ADDR_W-1:0] ack_addr,
    input  logic              ack_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [31:0]       acks_issued
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [META_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ACK_W-1:0]  rem;
    logic [ADDR_W-1:0] ack_addr_reg;
    logic [31:0]       acks_reg;

    logic [META_W-1:0] head;
    logic [ADDR_W-1:0] head_addr;
    logic [OPS_W-1:0]  head_ops;
    logic [ACK_W-1:0]  head_ack;
    logic              push;
    logic              pop;
    logic              ack_hs;
    logic              enter_ack;

    assign head      = mem[rd_ptr];
    assign head_addr = head[ADDR_W-1:0];
    assign head_ops  = head[ADDR_W+OPS_W-1:ADDR_W];
    assign head_ack  = head[META_W-1:ADDR_W+OPS_W];

    // Full is judged on the registered count only, so a same-cycle pop never
    // opens a full FIFO to a write.
    assign s_meta_tready = (count != CNT_W'(DEPTH));
    assign push          = s_meta_tvalid && s_meta_tready;
    assign pop           = m_valid && m_ready;
    assign ack_hs        = ack_valid && ack_ready;
    assign enter_ack     = pop && (ACK_EN != 0) && (head_ack != '0);

    assign m_addr      = m_valid ? head_addr : '0;
    assign m_ops       = m_valid ? head_ops  : '0;
    assign m_ack_count = m_valid ? head_ack  : '0;
    assign fifo_count  = count;
    assign ack_addr    = ack_addr_reg;
    assign acks_issued = acks_reg;

    // Next-state and handshake outputs: head is hidden while acks are pending.
    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        ack_valid  = 1'b0;
        case (state)
            IDLE: begin
                m_valid = (count != '0);
                if (enter_ack) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                ack_valid = 1'b1;
                if (ack_hs && (rem == ACK_W'(1))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage; contents are don't-care until counted, so no reset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_meta_tdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Ack bookkeeping: latch count/address on entry, count down per handshake.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rem          <= '0;
            ack_addr_reg <= '0;
            acks_reg     <= '0;
        end else begin
            if (enter_ack) begin
                rem          <= head_ack;
                ack_addr_reg <= head_addr;
            end else if (ack_hs) begin
                rem <= rem - ACK_W'(1);
            end
            if (ack_hs) begin
                acks_reg <= acks_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pmswitch_metadata_output_stream.sv
// Bench for pmswitch_metadata_output_stream: a default-parameter instance with
// ack expansion and a wide-address instance with acks disabled, checked by
// per-scenario tasks and a scoreboard of expected heads and ack addresses.
module tb_pmswitch_metadata_output_stream;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;
    int pops_a    = 0;

    // Instance A: defaults (32/8/8, depth 4, acks enabled)
    logic [47:0] a_tdata = '0;
    logic        a_tvalid = 1'b0;
    logic        a_tready;
    logic [31:0] a_m_addr;
    logic [7:0]  a_m_ops;
    logic [7:0]  a_m_ack;
    logic        a_m_valid;
    logic        a_m_ready = 1'b0;
    logic        a_ack_valid;
    logic [31:0] a_ack_addr;
    logic        a_ack_ready = 1'b0;
    logic [2:0]  a_count;
    logic [31:0] a_acks;

    // Instance B: 40/4/4, depth 8, acks disabled
    logic [47:0] b_tdata = '0;
    logic        b_tvalid = 1'b0;
    logic        b_tready;
    logic [39:0] b_m_addr;
    logic [3:0]  b_m_ops;
    logic [3:0]  b_m_ack;
    logic        b_m_valid;
    logic        b_m_ready = 1'b0;
    logic        b_ack_valid;
    logic [39:0] b_ack_addr;
    logic        b_ack_ready = 1'b1;
    logic [3:0]  b_count;
    logic [31:0] b_acks;

    pmswitch_metadata_output_stream dut_a (
        .aclk(clk), .aresetn(aresetn),
        .s_meta_tdata(a_tdata), .s_meta_tvalid(a_tvalid), .s_meta_tready(a_tready),
        .m_addr(a_m_addr), .m_ops(a_m_ops), .m_ack_count(a_m_ack),
        .m_valid(a_m_valid), .m_ready(a_m_ready),
        .ack_valid(a_ack_valid), .ack_addr(a_ack_addr), .ack_ready(a_ack_ready),
        .fifo_count(a_count), .acks_issued(a_acks)
    );

    pmswitch_metadata_output_stream #(
        .ADDR_W(40), .OPS_W(4), .ACK_W(4), .DEPTH(8), .ACK_EN(0)
    ) dut_b (
        .aclk(clk), .aresetn(aresetn),
        .s_meta_tdata(b_tdata), .s_meta_tvalid(b_tvalid), .s_meta_tready(b_tready),
        .m_addr(b_m_addr), .m_ops(b_m_ops), .m_ack_count(b_m_ack),
        .m_valid(b_m_valid), .m_ready(b_m_ready),
        .ack_valid(b_ack_valid), .ack_addr(b_ack_addr), .ack_ready(b_ack_ready),
        .fifo_count(b_count), .acks_issued(b_acks)
    );

    logic [47:0] exp_a[$];
    logic [31:0] exp_ack[$];
    logic [47:0] exp_b[$];

    // Scoreboard: record accepted words, check heads and ack beats as they leave.
    always @(negedge clk) begin
        if (aresetn) begin
            if (a_tvalid && a_tready) exp_a.push_back(a_tdata);
            if (b_tvalid && b_tready) exp_b.push_back(b_tdata);
            if (a_m_valid && a_m_ready) begin
                logic [47:0] e;
                pops_a++;
                tests_run++;
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL a_pop_unexpected: got %h, expected no entry", {a_m_ack, a_m_ops, a_m_addr});
                end else begin
                    e = exp_a.pop_front();
                    if ({a_m_ack, a_m_ops, a_m_addr} !== e) begin
                        failures++;
                        $display("FAIL a_head: got %h, expected %h", {a_m_ack, a_m_ops, a_m_addr}, e);
                    end
                    for (int k = 0; k < int'(e[47:40]); k++) exp_ack.push_back(e[31:0]);
                end
            end
            if (a_ack_valid && a_ack_ready) begin
                logic [31:0] ea;
                tests_run++;
                if (exp_ack.size() == 0) begin
                    failures++;
                    $display("FAIL a_ack_unexpected: got addr %h, expected no beat", a_ack_addr);
                end else begin
                    ea = exp_ack.pop_front();
                    if (a_ack_addr !== ea) begin
                        failures++;
                        $display("FAIL a_ack_addr: got %h, expected %h", a_ack_addr, ea);
                    end
                end
            end
            if (b_m_valid && b_m_ready) begin
                logic [47:0] eb;
                tests_run++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_pop_unexpected: got %h, expected no entry", {b_m_ack, b_m_ops, b_m_addr});
                end else begin
                    eb = exp_b.pop_front();
                    if ({b_m_ack, b_m_ops, b_m_addr} !== eb) begin
                        failures++;
                        $display("FAIL b_head: got %h, expected %h", {b_m_ack, b_m_ops, b_m_addr}, eb);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tests_run++;
        if ({a_m_valid, a_ack_valid, a_tready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_flags: got mv/av/rdy=%b, expected 001", {a_m_valid, a_ack_valid, a_tready});
        end
        tests_run++;
        if (a_count !== 3'd0 || a_acks !== 32'd0 || a_m_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_counts: got cnt=%0d acks=%0d addr=%h, expected 0/0/0", a_count, a_acks, a_m_addr);
        end
    endtask

    task automatic test_single();
        a_m_ready = 1'b1;
        a_ack_ready = 1'b1;
        a_tdata = 48'h03_05_DEADBEEF;
        a_tvalid = 1'b1;
        tick();
        a_tvalid = 1'b0;
        tests_run++;
        if (a_m_valid !== 1'b1 || a_m_addr !== 32'hDEADBEEF || a_m_ops !== 8'h05 || a_m_ack !== 8'h03) begin
            failures++;
            $display("FAIL single_head: got v=%b %h/%h/%h, expected 1 DEADBEEF/05/03", a_m_valid, a_m_addr, a_m_ops, a_m_ack);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (a_ack_valid !== 1'b1 || a_ack_addr !== 32'hDEADBEEF || a_m_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_ack%0d: got av=%b addr=%h mv=%b, expected 1 DEADBEEF 0", i, a_ack_valid, a_ack_addr, a_m_valid);
            end
            tick();
        end
        tests_run++;
        if (a_ack_valid !== 1'b0 || a_acks !== 32'd3) begin
            failures++;
            $display("FAIL single_done: got av=%b acks=%0d, expected 0 3", a_ack_valid, a_acks);
        end
    endtask

    task automatic test_fill();
        a_m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_tdata = {8'h00, 8'(i), 32'h1000_0000 + i};
            a_tvalid = 1'b1;
            tests_run++;
            if (a_tready !== (i < 4)) begin
                failures++;
                $display("FAIL fill_ready%0d: got %b, expected %b", i, a_tready, (i < 4));
            end
            tick();
        end
        a_tvalid = 1'b0;
        tests_run++;
        if (a_count !== 3'd4 || a_tready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b, expected 4 0", a_count, a_tready);
        end
        a_m_ready = 1'b1;
        a_tdata = 48'h00_77_2000_0000;
        a_tvalid = 1'b1;
        tests_run++;
        if (a_tready !== 1'b0) begin
            failures++;
            $display("FAIL fill_poppush_ready: got %b, expected 0", a_tready);
        end
        tick();
        a_tvalid = 1'b0;
        tests_run++;
        if (a_count !== 3'd3) begin
            failures++;
            $display("FAIL fill_poppush_count: got %0d, expected 3", a_count);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (a_count !== 3'd0 || a_m_valid !== 1'b0) begin
            failures++;
            $display("FAIL fill_drain: got cnt=%0d mv=%b, expected 0 0", a_count, a_m_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] w[3];
        int acks0;
        int pops0;
        w[0] = 48'h00_11_3000_0000;
        w[1] = 48'h00_22_3000_0001;
        w[2] = 48'h02_33_3000_0002;
        acks0 = int'(a_acks);
        pops0 = pops_a;
        a_m_ready = 1'b1;
        a_ack_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_tdata = w[i];
            a_tvalid = 1'b1;
            tick();
            tests_run++;
            if (a_ack_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_noack%0d: got av=%b, expected 0", i, a_ack_valid);
            end
        end
        a_tvalid = 1'b0;
        tests_run++;
        if (pops_a - pops0 != 2 || a_m_valid !== 1'b1 || a_m_ack !== 8'h02) begin
            failures++;
            $display("FAIL b2b_pops: got pops=%0d mv=%b cnt=%h, expected 2 1 02", pops_a - pops0, a_m_valid, a_m_ack);
        end
        tick();
        tests_run++;
        if (a_ack_valid !== 1'b1 || a_ack_addr !== 32'h3000_0002) begin
            failures++;
            $display("FAIL b2b_ack: got av=%b addr=%h, expected 1 30000002", a_ack_valid, a_ack_addr);
        end
        tick();
        tick();
        tests_run++;
        if (a_ack_valid !== 1'b0 || int'(a_acks) - acks0 != 2 || pops_a - pops0 != 3) begin
            failures++;
            $display("FAIL b2b_done: got av=%b dacks=%0d pops=%0d, expected 0 2 3", a_ack_valid, int'(a_acks) - acks0, pops_a - pops0);
        end
    endtask

    task automatic test_long_ack();
        int acks0;
        int hs;
        int cyc;
        int drop;
        int mv;
        acks0 = int'(a_acks);
        a_m_ready = 1'b1;
        a_ack_ready = 1'b0;
        a_tdata = 48'hFF_01_A5A5_0001;
        a_tvalid = 1'b1;
        tick();
        a_tdata = 48'h00_02_A5A5_0002;
        tick();
        a_tvalid = 1'b0;
        hs = 0;
        cyc = 0;
        drop = 0;
        mv = 0;
        while (hs < 255 && cyc < 2000) begin
            a_ack_ready = cyc[0];
            if (a_ack_valid !== 1'b1) drop++;
            if (a_m_valid !== 1'b0) mv++;
            if (a_ack_valid && a_ack_ready) hs++;
            tick();
            cyc++;
        end
        tests_run++;
        if (hs != 255 || drop != 0) begin
            failures++;
            $display("FAIL long_handshakes: got hs=%0d drops=%0d, expected 255 0", hs, drop);
        end
        tests_run++;
        if (mv != 0) begin
            failures++;
            $display("FAIL long_mvalid: got %0d cycles with m_valid during ACK, expected 0", mv);
        end
        tests_run++;
        if (a_ack_valid !== 1'b0 || int'(a_acks) - acks0 != 255 || a_m_valid !== 1'b1) begin
            failures++;
            $display("FAIL long_done: got av=%b dacks=%0d mv=%b, expected 0 255 1", a_ack_valid, int'(a_acks) - acks0, a_m_valid);
        end
        a_ack_ready = 1'b1;
        tick();
        tests_run++;
        if (a_count !== 3'd0) begin
            failures++;
            $display("FAIL long_drain: got cnt=%0d, expected 0", a_count);
        end
    endtask

    task automatic test_reset_mid_ack();
        a_m_ready = 1'b1;
        a_ack_ready = 1'b0;
        a_tdata = 48'h05_09_5000_0001;
        a_tvalid = 1'b1;
        tick();
        a_tdata = 48'h00_0A_5000_0002;
        tick();
        a_tdata = 48'h00_0B_5000_0003;
        tick();
        a_tvalid = 1'b0;
        tests_run++;
        if (a_count !== 3'd2 || a_ack_valid !== 1'b1) begin
            failures++;
            $display("FAIL midack_setup: got cnt=%0d av=%b, expected 2 1", a_count, a_ack_valid);
        end
        aresetn = 1'b0;
        tick();
        tests_run++;
        if ({a_ack_valid, a_m_valid, a_tready} !== 3'b001 || a_count !== 3'd0 || a_acks !== 32'd0 || a_ack_addr !== 32'd0) begin
            failures++;
            $display("FAIL midack_reset: got av/mv/rdy=%b cnt=%0d acks=%0d addr=%h, expected 001 0 0 0",
                     {a_ack_valid, a_m_valid, a_tready}, a_count, a_acks, a_ack_addr);
        end
        exp_a.delete();
        exp_ack.delete();
        exp_b.delete();
        aresetn = 1'b1;
        a_ack_ready = 1'b1;
        tick();
    endtask

    task automatic test_params();
        int bad_av;
        b_m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b_tdata = {4'hA, 4'(i), 40'h12_3456_7800 + 40'(i)};
            b_tvalid = 1'b1;
            tests_run++;
            if (b_tready !== (i < 8)) begin
                failures++;
                $display("FAIL p_ready%0d: got %b, expected %b", i, b_tready, (i < 8));
            end
            tick();
        end
        b_tvalid = 1'b0;
        tests_run++;
        if (b_count !== 4'd8 || b_m_valid !== 1'b1 || b_m_addr !== 40'h12_3456_7800 || b_m_ops !== 4'h0 || b_m_ack !== 4'hA) begin
            failures++;
            $display("FAIL p_split: got cnt=%0d v=%b %h/%h/%h, expected 8 1 1234567800/0/a",
                     b_count, b_m_valid, b_m_addr, b_m_ops, b_m_ack);
        end
        b_m_ready = 1'b1;
        bad_av = 0;
        for (int i = 0; i < 8; i++) begin
            if (b_ack_valid !== 1'b0) bad_av++;
            tick();
        end
        tests_run++;
        if (bad_av != 0 || b_ack_valid !== 1'b0 || b_acks !== 32'd0 || b_ack_addr !== 40'd0) begin
            failures++;
            $display("FAIL p_noack: got bad=%0d av=%b acks=%0d addr=%h, expected 0 0 0 0", bad_av, b_ack_valid, b_acks, b_ack_addr);
        end
        tests_run++;
        if (b_count !== 4'd0 || b_m_valid !== 1'b0 || b_m_addr !== 40'd0) begin
            failures++;
            $display("FAIL p_drain: got cnt=%0d mv=%b addr=%h, expected 0 0 0", b_count, b_m_valid, b_m_addr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_long_ack();
        test_reset_mid_ack();
        test_params();
        tick();
        tests_run++;
        if (exp_a.size() != 0 || exp_ack.size() != 0 || exp_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d/%0d/%0d pending, expected 0/0/0", exp_a.size(), exp_ack.size(), exp_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "timeout");
    end

endmodule
